button_event_decoder: RTL and testbench
=======================================

Name: button_event_decoder

Overview:
- Downstream consumer of the debouncer's `debounced` level.
- Turns the clean button level into single-cycle event pulses: press, release, short click, long press and auto-repeat, plus a held level.
- Timing is measured in `tick` periods, using the same slow tick strobe that drives the debouncer.
- Feeds the UI/mode-control logic, which acts only on event pulses and never on raw levels.

Parameters:
- CNT_W, 8, width of the tick counters.
- LONG_TICKS, 100, ticks the button must stay held before long_press fires. Legal range 1..2^CNT_W.
- REPEAT_TICKS, 25, ticks between repeat pulses once in the long state. 0 disables repeat. Legal range 0..2^CNT_W.

Ports:
- clk  input  1  system clock.
- rst_sync  input  1  reset, asynchronous, active-high.
- tick  input  1  one-clk strobe from the tick prescaler.
- debounced  input  1  clean button level from the debouncer; already synchronous to clk.
- press  output  1  one-clk pulse on each press.
- release  output  1  one-clk pulse on each release.
- short_click  output  1  one-clk pulse on a release that happens before long_press.
- long_press  output  1  one-clk pulse when the hold reaches LONG_TICKS.
- repeat  output  1  one-clk pulse every REPEAT_TICKS while still held after long_press.
- held  output  1  level, high while state is not IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - hold_cnt and rpt_cnt 0.
  - prev_q (registered copy of debounced) resets to 1. A button held through reset therefore gives no press; it must be released and pressed again.
- Edge detection: rise = debounced & ~prev_q; fall = ~debounced & prev_q. prev_q <= debounced every clk.
- All event outputs are registered. A pulse is high for exactly one clk, in the cycle after the clk edge on which the condition is evaluated. held is registered and updates on the same edge as the state.
- States and transitions:
  - IDLE:
    - On rise: go to PRESSED, hold_cnt <= 0, press <= 1.
    - tick is ignored in IDLE.
  - PRESSED:
    - On fall: go to IDLE, release <= 1, short_click <= 1.
    - Else on tick:
      - If hold_cnt == LONG_TICKS-1: go to LONG, long_press <= 1, rpt_cnt <= 0.
      - Otherwise hold_cnt <= hold_cnt+1.
  - LONG:
    - On fall: go to IDLE, release <= 1. short_click stays 0.
    - Else on tick, with REPEAT_TICKS != 0:
      - If rpt_cnt == REPEAT_TICKS-1: repeat <= 1, rpt_cnt <= 0.
      - Otherwise rpt_cnt <= rpt_cnt+1.
- Counters never wrap in an unintended way:
  - hold_cnt stops incrementing in LONG.
  - rpt_cnt is used only in LONG.
  - Comparisons are done at CNT_W bits. Parameter values outside the legal range are illegal; the behaviour is then undefined and caught by a simulation assertion.
- Simultaneous events:
  - fall and tick in the same clk: fall wins. No long_press or repeat is issued; release is issued, plus short_click if in PRESSED.
  - rise and tick in IDLE: press only; hold_cnt starts at 0.
- Latency: press fires 1 clk after the first clk sampling debounced=1. With LONG_TICKS=N, long_press fires on the Nth tick strictly after the press clk.
- Events are mutually exclusive per cycle except release+short_click, which pulse together.
- Reset mid-operation: immediate return to reset values with no release pulse. After reset deasserts, prev_q=1 suppresses a ghost press.
- The block never alters debounced and adds no filtering of its own.

Test Plan:
- Basic short click: reset, debounced 0→1, hold 3 ticks, then 1→0 (LONG_TICKS=100). Required: press 1 clk after the rise; release and short_click together 1 clk after the fall; no long_press; held high exactly between them.
- Long press with repeat: LONG_TICKS=4, REPEAT_TICKS=2, hold for 10 ticks. Required: long_press on the 4th tick; repeat on ticks 6, 8, 10; on release, release pulses with short_click=0.
- Fall collides with tick: LONG_TICKS=4, fall in the same clk as the 4th tick. Required: no long_press; release and short_click pulse.
- Held through reset: debounced=1 while rst_sync is asserted, then deasserted. Required: no press. After 0→1 again: press.
- Reset mid-hold: assert rst_sync in LONG. Required: all outputs 0 asynchronously; no release pulse after reset deasserts, even if debounced goes low.
- Repeat disabled: REPEAT_TICKS=0, hold 50 ticks after long_press. Required: repeat never asserts; held stays 1.

Source files
------------

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press/release/click/long/repeat
// pulses plus a held level. All timing is counted in tick strobes.
module button_event_decoder #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned LONG_TICKS   = 100,
    parameter int unsigned REPEAT_TICKS = 25
) (
    input  logic i_clk,
    input  logic i_rst_sync,
    input  logic i_tick,
    input  logic i_debounced,
    output logic o_press,
    output logic o_release,
    output logic o_short_click,
    output logic o_long_press,
    output logic o_repeat,
    output logic o_held
);

    localparam longint unsigned MAX_TICKS   = 64'(1) << CNT_W;
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_TICKS - 1);
    localparam bit               REPEAT_EN  = (REPEAT_TICKS != 0);
    localparam bit               PARAMS_OK  = (LONG_TICKS >= 1)
                                           && (64'(LONG_TICKS) <= MAX_TICKS)
                                           && (64'(REPEAT_TICKS) <= MAX_TICKS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LONG    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             r_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_hold_done;
    logic             w_rpt_done;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_short_click_nxt;
    logic             w_long_press_nxt;
    logic             w_repeat_nxt;
    logic             w_held_nxt;

    assign w_rise      = i_debounced & ~r_prev;
    assign w_fall      = ~i_debounced & r_prev;
    assign w_hold_done = (r_hold_cnt == LONG_LAST);
    assign w_rpt_done  = (r_rpt_cnt == RPT_LAST);

    // prev resets high so a button held through reset never yields a press
    always_ff @(posedge i_clk or posedge i_rst_sync) begin
        if (i_rst_sync) begin
            r_state       <= S_IDLE;
            r_hold_cnt    <= '0;
            r_rpt_cnt     <= '0;
            r_prev        <= 1'b1;
            o_press       <= 1'b0;
            o_release     <= 1'b0;
            o_short_click <= 1'b0;
            o_long_press  <= 1'b0;
            o_repeat      <= 1'b0;
            o_held        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_cnt_nxt;
            r_rpt_cnt     <= w_rpt_cnt_nxt;
            r_prev        <= i_debounced;
            o_press       <= w_press_nxt;
            o_release     <= w_release_nxt;
            o_short_click <= w_short_click_nxt;
            o_long_press  <= w_long_press_nxt;
            o_repeat      <= w_repeat_nxt;
            o_held        <= w_held_nxt;
        end
    end

    // Next state and counters; a fall always wins over a coincident tick
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_rpt_cnt_nxt  = r_rpt_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt    = S_PRESSED;
                    w_hold_cnt_nxt = '0;
                end
            end
            S_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                end else if (i_tick) begin
                    if (w_hold_done) begin
                        w_state_nxt   = S_LONG;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                    end
                end
            end
            S_LONG: begin
                if (w_fall) begin
                    w_state_nxt = S_IDLE;
                end else if (i_tick && REPEAT_EN) begin
                    if (w_rpt_done) begin
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered event pulses
    always_comb begin
        w_press_nxt       = 1'b0;
        w_release_nxt     = 1'b0;
        w_short_click_nxt = 1'b0;
        w_long_press_nxt  = 1'b0;
        w_repeat_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_press_nxt = w_rise;
            end
            S_PRESSED: begin
                w_release_nxt     = w_fall;
                w_short_click_nxt = w_fall;
                w_long_press_nxt  = ~w_fall & i_tick & w_hold_done;
            end
            S_LONG: begin
                w_release_nxt = w_fall;
                w_repeat_nxt  = ~w_fall & i_tick & REPEAT_EN & w_rpt_done;
            end
            default: begin
                w_press_nxt = 1'b0;
            end
        endcase
        w_held_nxt = (w_state_nxt != S_IDLE);
    end

    a_params_legal: assert property (@(posedge i_clk) PARAMS_OK);

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: three parameterisations driven in parallel,
// checked by fixed vectors, directed reset/repeat sequences and a random run.
module tb_button_event_decoder;

    localparam int NDUT = 3;
    localparam int ML [NDUT] = '{100, 4, 4};
    localparam int MR [NDUT] = '{25, 2, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic deb = 1'b0;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    // {press, release, short_click, long_press, repeat, held}
    wire [5:0] outs [NDUT];
    logic [5:0] m_exp [NDUT];
    logic       m_down [NDUT];
    logic       m_prev [NDUT];
    int         m_ticks [NDUT];

    always #5 clk = ~clk;

    logic a_p, a_r, a_s, a_l, a_t, a_h;
    logic b_p, b_r, b_s, b_l, b_t, b_h;
    logic c_p, c_r, c_s, c_l, c_t, c_h;

    button_event_decoder #(.CNT_W(8), .LONG_TICKS(100), .REPEAT_TICKS(25)) dut_a (
        .i_clk(clk), .i_rst_sync(rst), .i_tick(tick), .i_debounced(deb),
        .o_press(a_p), .o_release(a_r), .o_short_click(a_s),
        .o_long_press(a_l), .o_repeat(a_t), .o_held(a_h));
    button_event_decoder #(.CNT_W(8), .LONG_TICKS(4), .REPEAT_TICKS(2)) dut_b (
        .i_clk(clk), .i_rst_sync(rst), .i_tick(tick), .i_debounced(deb),
        .o_press(b_p), .o_release(b_r), .o_short_click(b_s),
        .o_long_press(b_l), .o_repeat(b_t), .o_held(b_h));
    button_event_decoder #(.CNT_W(8), .LONG_TICKS(4), .REPEAT_TICKS(0)) dut_c (
        .i_clk(clk), .i_rst_sync(rst), .i_tick(tick), .i_debounced(deb),
        .o_press(c_p), .o_release(c_r), .o_short_click(c_s),
        .o_long_press(c_l), .o_repeat(c_t), .o_held(c_h));

    assign outs[0] = {a_p, a_r, a_s, a_l, a_t, a_h};
    assign outs[1] = {b_p, b_r, b_s, b_l, b_t, b_h};
    assign outs[2] = {c_p, c_r, c_s, c_l, c_t, c_h};

    // Reference: time since press counted in ticks; events derived arithmetically
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NDUT; k++) begin
                m_down[k]  = 1'b0;
                m_prev[k]  = 1'b1;
                m_ticks[k] = 0;
                m_exp[k]   = '0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                logic rise, fall, p, rl, sc, lp, rp;
                rise = deb & ~m_prev[k];
                fall = ~deb & m_prev[k];
                m_prev[k] = deb;
                {p, rl, sc, lp, rp} = '0;
                if (!m_down[k]) begin
                    if (rise) begin
                        m_down[k]  = 1'b1;
                        m_ticks[k] = 0;
                        p = 1'b1;
                    end
                end else if (fall) begin
                    rl = 1'b1;
                    sc = (m_ticks[k] < ML[k]);
                    m_down[k] = 1'b0;
                end else if (tick) begin
                    m_ticks[k]++;
                    if (m_ticks[k] == ML[k])
                        lp = 1'b1;
                    else if (MR[k] != 0 && m_ticks[k] > ML[k] && ((m_ticks[k] - ML[k]) % MR[k]) == 0)
                        rp = 1'b1;
                end
                m_exp[k] = {p, rl, sc, lp, rp, m_down[k]};
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                n_tests++;
                if (outs[k] !== m_exp[k]) begin
                    n_fail++;
                    $display("FAIL model dut%0d t=%0t got=%b exp=%b", k, $time, outs[k], m_exp[k]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b exp=%b", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic d, input logic t);
        deb  = d;
        tick = t;
        @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic       d;
        logic       t;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [20];
    int   rp_b, rp_c, lp_b;
    int   den [3] = '{8, 64, 400};

    initial begin
        // Vectors for LONG_TICKS=4, REPEAT_TICKS=2: fall/tick collision, then long+repeat
        vecs[0]  = '{1'b0, 1'b0, 6'b000000};
        vecs[1]  = '{1'b1, 1'b0, 6'b100001};
        vecs[2]  = '{1'b1, 1'b1, 6'b000001};
        vecs[3]  = '{1'b1, 1'b0, 6'b000001};
        vecs[4]  = '{1'b1, 1'b1, 6'b000001};
        vecs[5]  = '{1'b1, 1'b1, 6'b000001};
        vecs[6]  = '{1'b0, 1'b1, 6'b011000};
        vecs[7]  = '{1'b0, 1'b0, 6'b000000};
        vecs[8]  = '{1'b1, 1'b1, 6'b100001};
        vecs[9]  = '{1'b1, 1'b1, 6'b000001};
        vecs[10] = '{1'b1, 1'b1, 6'b000001};
        vecs[11] = '{1'b1, 1'b1, 6'b000001};
        vecs[12] = '{1'b1, 1'b1, 6'b000101};
        vecs[13] = '{1'b1, 1'b1, 6'b000001};
        vecs[14] = '{1'b1, 1'b1, 6'b000011};
        vecs[15] = '{1'b1, 1'b0, 6'b000001};
        vecs[16] = '{1'b1, 1'b1, 6'b000001};
        vecs[17] = '{1'b1, 1'b1, 6'b000011};
        vecs[18] = '{1'b0, 1'b1, 6'b010000};
        vecs[19] = '{1'b0, 1'b0, 6'b000000};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < NDUT; k++) chk($sformatf("reset_state dut%0d", k), outs[k], 6'b000000);
        rst = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].d, vecs[i].t);
            chk($sformatf("vec[%0d]", i), outs[1], vecs[i].exp);
        end

        // Button held through reset must not produce a press
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            for (int k = 0; k < NDUT; k++)
                chk($sformatf("no_ghost_press dut%0d", k), {5'b0, outs[k][5]}, 6'b000000);
        end
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("press_after_reset dut%0d", k), {5'b0, outs[k][5]}, 6'b000001);
        step(1'b0, 1'b0);

        // Reset asserted while in the long state
        step(1'b1, 1'b0);
        repeat (6) step(1'b1, 1'b1);
        chk("held_before_reset dut1", {5'b0, outs[1][0]}, 6'b000001);
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) chk($sformatf("async_reset dut%0d", k), outs[k], 6'b000000);
        repeat (2) step(1'b1, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            for (int k = 0; k < NDUT; k++)
                chk($sformatf("no_release_after_reset dut%0d", k), outs[k], 6'b000000);
        end

        // Long hold: repeat disabled on dut_c, every 2 ticks on dut_b
        rp_b = 0; rp_c = 0; lp_b = 0;
        step(1'b1, 1'b0);
        for (int i = 0; i < 54; i++) begin
            step(1'b1, 1'b1);
            rp_b += int'(outs[1][1]);
            rp_c += int'(outs[2][1]);
            lp_b += int'(outs[1][2]);
        end
        chk("repeat_disabled_count", 6'(rp_c), 6'd0);
        chk("repeat_count_b", 6'(rp_b), 6'd25);
        chk("long_count_b", 6'(lp_b), 6'd1);
        chk("held_c_long", {5'b0, outs[2][0]}, 6'b000001);
        step(1'b0, 1'b0);
        chk("long_release_c", outs[2], 6'b010000);
        chk("short_release_a", outs[0], 6'b011000);

        // Random run with varying hold lengths and occasional resets
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 1500; i++) begin
                logic d;
                d = deb;
                if ($urandom_range(den[b] - 1) == 0) d = ~d;
                if ($urandom_range(999) == 0) rst = 1'b1;
                step(d, 1'($urandom_range(1)));
                rst = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
